// File: rtl/dotprod_pkg.sv
// Shared constants and bank-state encoding for the dot-product operand path.
// No logic; imported by the loader and its banks.
package dotprod_pkg;

    localparam int N_DEF   = 32;
    localparam int LEN_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/dot_vec_bank.sv
// One operand bank: LEN-slot a/b register pair filled in order, zero-padded on close.
// Write lands next cycle; the owner must not write while FULL, release empties it.
module dot_vec_bank
    import dotprod_pkg::*;
#(
    parameter  int N   = N_DEF,
    parameter  int LEN = LEN_DEF,
    localparam int CW  = $clog2(LEN + 1),
    localparam int IW  = $clog2(LEN)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_last,
    input  logic [N-1:0] wr_a,
    input  logic [N-1:0] wr_b,
    input  logic        rd_release,
    output bank_state_e state,
    output logic        wr_close,
    output logic [N-1:0] slot_a [LEN],
    output logic [N-1:0] slot_b [LEN],
    output logic [CW-1:0] count
);

    bank_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  a_q [LEN];
    logic [N-1:0]  a_d [LEN];
    logic [N-1:0]  b_q [LEN];
    logic [N-1:0]  b_d [LEN];

    assign wr_close = wr_en && (wr_last || (idx_q == IW'(LEN - 1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        if (wr_en) begin
            a_d[idx_q] = wr_a;
            b_d[idx_q] = wr_b;
            if (wr_close) begin
                // Clear the unused tail so stale slots never reach the product.
                for (int k = 0; k < LEN; k++) begin
                    if (k > int'(idx_q)) begin
                        a_d[k] = '0;
                        b_d[k] = '0;
                    end
                end
                count_d = CW'(idx_q) + CW'(1);
                idx_d   = '0;
                state_d = FULL;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = FILLING;
            end
        end else if (rd_release) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < LEN; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state  = state_q;
        count  = count_q;
        slot_a = a_q;
        slot_b = b_q;
    end

endmodule

// File: rtl/dot_vec_loader.sv
// Ping-pong operand loader: streams element pairs into two banks and presents whole vectors.
// vec_valid one cycle after the closing accept; in_ready drops only while the fill bank is FULL.
module dot_vec_loader
    import dotprod_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int LEN = LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_a,
    input  logic [N-1:0]               in_b,
    input  logic                       in_last,
    output logic                       vec_valid,
    input  logic                       vec_ready,
    output logic [N-1:0]               vec_a [LEN],
    output logic [N-1:0]               vec_b [LEN],
    output logic [$clog2(LEN+1)-1:0]   vec_count
);

    localparam int CW = $clog2(LEN + 1);

    logic        fill_ptr_q, fill_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    bank_state_e st0, st1;
    bank_state_e fill_state, rd_state;
    logic        close0, close1;
    logic        accept, consume;
    logic        wr0, wr1, rel0, rel1;
    logic [N-1:0]  a0 [LEN];
    logic [N-1:0]  b0 [LEN];
    logic [N-1:0]  a1 [LEN];
    logic [N-1:0]  b1 [LEN];
    logic [CW-1:0] cnt0, cnt1;

    assign fill_state = fill_ptr_q ? st1 : st0;
    assign rd_state   = rd_ptr_q ? st1 : st0;
    assign in_ready   = !rst && (fill_state != FULL);
    assign accept     = in_valid && in_ready;
    assign vec_valid  = !rst && (rd_state == FULL);
    assign consume    = vec_valid && vec_ready;
    assign wr0        = accept && !fill_ptr_q;
    assign wr1        = accept && fill_ptr_q;
    assign rel0       = consume && !rd_ptr_q;
    assign rel1       = consume && rd_ptr_q;

    dot_vec_bank #(.N(N), .LEN(LEN)) u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr0),
        .wr_last    (in_last),
        .wr_a       (in_a),
        .wr_b       (in_b),
        .rd_release (rel0),
        .state      (st0),
        .wr_close   (close0),
        .slot_a     (a0),
        .slot_b     (b0),
        .count      (cnt0)
    );

    dot_vec_bank #(.N(N), .LEN(LEN)) u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr1),
        .wr_last    (in_last),
        .wr_a       (in_a),
        .wr_b       (in_b),
        .rd_release (rel1),
        .state      (st1),
        .wr_close   (close1),
        .slot_a     (a1),
        .slot_b     (b1),
        .count      (cnt1)
    );

    // Banks are closed and consumed in the same order, so each pointer just toggles.
    always_comb begin
        fill_ptr_d = fill_ptr_q ^ (close0 | close1);
        rd_ptr_d   = rd_ptr_q ^ consume;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_ptr_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_comb begin
        vec_count = '0;
        for (int k = 0; k < LEN; k++) begin
            vec_a[k] = '0;
            vec_b[k] = '0;
        end
        if (!rst) begin
            vec_count = rd_ptr_q ? cnt1 : cnt0;
            for (int k = 0; k < LEN; k++) begin
                vec_a[k] = rd_ptr_q ? a1[k] : a0[k];
                vec_b[k] = rd_ptr_q ? b1[k] : b0[k];
            end
        end
    end

endmodule

// File: tb/tb_dot_vec_loader.sv
// Bench for dot_vec_loader: table of vectors plus hand sequences for backpressure and reset,
// with a queue of expected vectors compared whenever the DUT hands one off.
module tb_dot_vec_loader;
    import dotprod_pkg::*;

    localparam int N   = 32;
    localparam int LEN = 4;
    localparam int CW  = $clog2(LEN + 1);

    typedef logic [LEN-1:0][N-1:0] quad_t;
    typedef struct {
        int    n;
        bit    use_last;
        quad_t ia;
        quad_t ib;
        quad_t ea;
        quad_t eb;
        int    ecnt;
    } rec_t;
    typedef struct {
        quad_t a;
        quad_t b;
        int    cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          in_last = 1'b0;
    logic          vec_valid;
    logic          vec_ready = 1'b0;
    logic [N-1:0]  vec_a [LEN];
    logic [N-1:0]  vec_b [LEN];
    logic [CW-1:0] vec_count;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_popped = 0;
    int   vv_run = 0;
    int   vv_max = 0;
    int   rdy_drops = 0;
    bit   track_rdy = 1'b0;
    exp_t exp_q[$];
    rec_t tbl[5];

    always #5 clk = ~clk;

    dot_vec_loader #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .vec_count (vec_count)
    );

    function automatic quad_t q4(input logic [N-1:0] e0, e1, e2, e3);
        quad_t r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        return r;
    endfunction

    function automatic rec_t mk(input int n, input bit ul, input quad_t ia, ib, ea, eb,
                                input int ecnt);
        rec_t r;
        r.n = n; r.use_last = ul; r.ia = ia; r.ib = ib; r.ea = ea; r.eb = eb; r.ecnt = ecnt;
        return r;
    endfunction

    function automatic quad_t pack_a();
        quad_t r;
        for (int k = 0; k < LEN; k++) r[k] = vec_a[k];
        return r;
    endfunction

    function automatic quad_t pack_b();
        quad_t r;
        for (int k = 0; k < LEN; k++) r[k] = vec_b[k];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the pair is accepted.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
        int budget;
        budget = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", budget);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_rec(input rec_t r, input bit push);
        exp_t e;
        if (push) begin
            e.a = r.ea; e.b = r.eb; e.cnt = r.ecnt;
            exp_q.push_back(e);
        end
        for (int i = 0; i < r.n; i++) send(r.ia[i], r.ib[i], r.use_last && (i == r.n - 1));
    endtask

    // Scoreboard side: every handoff is matched against the oldest expected vector.
    always @(negedge clk) begin
        exp_t e;
        if (vec_valid) vv_run++;
        else vv_run = 0;
        if (vv_run > vv_max) vv_max = vv_run;
        if (track_rdy && in_valid && !in_ready) rdy_drops++;
        if (!rst && vec_valid && vec_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_vec: got vector a0=%0h count=%0d, required none", vec_a[0], vec_count);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                check("vec_a", pack_a(), e.a);
                check("vec_b", pack_b(), e.b);
                check("vec_count", 128'(vec_count), 128'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t ra, rs, r1, r2, r3, rf, rn;
        int   pc;

        tbl[0] = mk(4, 1'b1, q4(1, 2, 3, 4), q4(5, 6, 7, 8), q4(1, 2, 3, 4), q4(5, 6, 7, 8), 4);
        tbl[1] = mk(2, 1'b1, q4(9, 3, 55, 66), q4(2, 3, 77, 88), q4(9, 3, 0, 0), q4(2, 3, 0, 0), 2);
        tbl[2] = mk(1, 1'b1, q4(7, 99, 99, 99), q4(7, 99, 99, 99), q4(7, 0, 0, 0), q4(7, 0, 0, 0), 1);
        tbl[3] = mk(4, 1'b0, q4(10, 20, 30, 40), q4(1, 1, 1, 1), q4(10, 20, 30, 40), q4(1, 1, 1, 1), 4);
        tbl[4] = mk(3, 1'b1, q4(32'hffff_ffff, 2, 3, 5), q4(4, 5, 6, 5),
                    q4(32'hffff_ffff, 2, 3, 0), q4(4, 5, 6, 0), 3);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_vec_valid", 128'(vec_valid), 128'(0));
        check("rst_vec_count", 128'(vec_count), 128'(0));
        check("rst_vec_a", pack_a(), '0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 128'(in_ready), 128'(1));
        sync();

        // Table vectors, one at a time with the consumer always ready
        vec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_vv", 128'(vec_valid), 128'(0));
            sync();
            send_rec(tbl[i], 1'b1);
            @(negedge clk);
            check("lat_vv", 128'(vec_valid), 128'(1));
            sync();
        end
        repeat (2) sync();

        // Back-to-back: a 4-pair vector then four single-pair vectors, no gaps
        ra = mk(4, 1'b1, q4(41, 42, 43, 44), q4(51, 52, 53, 54), q4(41, 42, 43, 44), q4(51, 52, 53, 54), 4);
        vv_max = 0;
        rdy_drops = 0;
        track_rdy = 1'b1;
        send_rec(ra, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rs = mk(1, 1'b1, q4(11 + i, 0, 0, 0), q4(21 + i, 0, 0, 0),
                    q4(11 + i, 0, 0, 0), q4(21 + i, 0, 0, 0), 1);
            send_rec(rs, 1'b1);
        end
        track_rdy = 1'b0;
        repeat (3) sync();
        check("b2b_rdy_drops", 128'(rdy_drops), 128'(0));
        check("b2b_vv_run", 128'(vv_max), 128'(5));

        // Both banks full with consumer stalled, then a single-cycle consume
        vec_ready = 1'b0;
        r1 = mk(4, 1'b1, q4(101, 102, 103, 104), q4(201, 202, 203, 204),
                q4(101, 102, 103, 104), q4(201, 202, 203, 204), 4);
        r2 = mk(4, 1'b1, q4(105, 106, 107, 108), q4(205, 206, 207, 208),
                q4(105, 106, 107, 108), q4(205, 206, 207, 208), 4);
        r3 = mk(4, 1'b1, q4(109, 110, 111, 112), q4(209, 210, 211, 212),
                q4(109, 110, 111, 112), q4(209, 210, 211, 212), 4);
        send_rec(r1, 1'b1);
        send_rec(r2, 1'b1);
        @(negedge clk);
        check("full_rdy", 128'(in_ready), 128'(0));
        check("full_vv", 128'(vec_valid), 128'(1));
        check("full_count", 128'(vec_count), 128'(4));
        sync();
        fork
            send_rec(r3, 1'b1);
            begin
                @(negedge clk);
                check("full_hold_rdy", 128'(in_ready), 128'(0));
                check("full_hold_a0", 128'(vec_a[0]), 128'(101));
                sync();
                sync();
                vec_ready = 1'b1;
                sync();
                vec_ready = 1'b0;
                @(negedge clk);
                check("rdy_after_consume", 128'(in_ready), 128'(1));
                check("next_presented_a0", 128'(vec_a[0]), 128'(105));
            end
        join
        vec_ready = 1'b1;
        repeat (4) sync();

        // Reset with one FULL bank and a partial vector in the other
        vec_ready = 1'b0;
        rf = mk(4, 1'b1, q4(61, 62, 63, 64), q4(71, 72, 73, 74), q4(61, 62, 63, 64), q4(71, 72, 73, 74), 4);
        send_rec(rf, 1'b1);
        send(31, 41, 1'b0);
        send(32, 42, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_rdy", 128'(in_ready), 128'(0));
        check("mid_rst_vv", 128'(vec_valid), 128'(0));
        check("mid_rst_a", pack_a(), '0);
        check("mid_rst_count", 128'(vec_count), 128'(0));
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 128'(in_ready), 128'(1));
        check("post_rst_vv", 128'(vec_valid), 128'(0));
        check("post_rst_a", pack_a(), '0);
        check("post_rst_b", pack_b(), '0);
        sync();
        vec_ready = 1'b1;
        pc = n_popped;
        rn = mk(4, 1'b1, q4(81, 82, 83, 84), q4(91, 92, 93, 94), q4(81, 82, 83, 84), q4(91, 92, 93, 94), 4);
        send_rec(rn, 1'b1);
        repeat (3) sync();
        check("post_rst_handoffs", 128'(n_popped - pc), 128'(1));
        @(negedge clk);
        check("post_rst_idle_vv", 128'(vec_valid), 128'(0));
        sync();

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_vec_loader.md
DOT_VEC_LOADER -- requirements
Module: dot_vec_loader

Interface
REQ-001 SHALL have parameter N, default 32: element width in bits; matches the dot-product stage width.
REQ-002 SHALL have parameter LEN, default 4: elements per vector; LEN >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: the element pair on in_a/in_b is valid.
REQ-006 SHALL have port in_ready, output, 1: the loader can accept an element pair this cycle.
REQ-007 SHALL have port in_a, input, N: element of the row vector.
REQ-008 SHALL have port in_b, input, N: element of the column vector.
REQ-009 SHALL have port in_last, input, 1: marks the final pair of the current vector; qualified by in_valid.
REQ-010 SHALL have port vec_valid, output, 1: vec_a/vec_b/vec_count hold a complete vector.
REQ-011 SHALL have port vec_ready, input, 1: the downstream dot-product stage consumes the presented vector.
REQ-012 SHALL have port vec_a, output, N x LEN unpacked array: row operand, index 0 = first element received.
REQ-013 SHALL have port vec_b, output, N x LEN unpacked array: column operand, same indexing as vec_a.
REQ-014 SHALL have port vec_count, output, $clog2(LEN+1): number of real (non-padded) elements in the presented vector.

Function
REQ-015 SHALL accept a pair only when in_valid and in_ready are both high in the same cycle.
REQ-016 SHALL write the k-th accepted pair of a vector to slot k of the fill bank, k = 0..LEN-1.
REQ-017 SHALL close a vector on the accepted pair with in_last=1, or on the LEN-th accepted pair, whichever comes first.
REQ-018 SHALL zero slots k+1..LEN-1 of both operands in the closing cycle when the vector closes at index k < LEN-1, so the dot product stays exact.
REQ-019 SHALL set vec_count to k+1 for the closed vector.
REQ-020 SHALL use two banks (ping-pong), each with states EMPTY -> FILLING (first accept) -> FULL (close) -> EMPTY (vec_valid && vec_ready); a pair that is both first and closing goes directly EMPTY -> FULL.
REQ-021 SHALL drive in_ready=1 exactly when the current fill bank is not FULL.
REQ-022 SHALL raise vec_valid in the cycle after the closing accept (1-cycle latency) when the output bank is otherwise idle.
REQ-023 SHALL hold vec_a, vec_b and vec_count stable while vec_valid=1 and vec_ready=0.
REQ-024 SHALL present banks strictly in fill order and toggle the read bank on each consume.
REQ-025 SHALL sustain one pair per cycle with no bubble between back-to-back vectors while vec_ready stays high.
REQ-026 SHALL, on a closing accept and a consume in the same cycle, complete both: the consumed bank goes EMPTY and the closed bank goes FULL.
REQ-027 SHALL, when both banks are FULL, hold in_ready=0 until a consume occurs; in_ready returns to 1 in the cycle after the consume.
REQ-028 SHALL ignore in_last when in_valid=0 or in_ready=0.

Reset
REQ-029 SHALL, while rst=1, set both banks EMPTY, fill and read bank pointers to 0, the element index to 0, and vec_valid=0.
REQ-030 SHALL output in_ready=0, and vec_a, vec_b and vec_count all zero, during reset.
REQ-031 SHALL discard any partial or FULL vector when rst is asserted mid-operation; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL import package dotprod_pkg, which holds the default N and LEN constants and the bank-state enum (EMPTY, FILLING, FULL).
REQ-033 SHALL instantiate two copies of sub-module dot_vec_bank (LEN-slot register pair with write index, zero-pad-on-close, and count); the ping-pong control stays in dot_vec_loader.

Verification
REQ-034 SHALL cover: 4 pairs (1,5),(2,6),(3,7),(4,8), last on the 4th, vec_ready=1 -> vec_valid 1 cycle later; vec_a={1,2,3,4}, vec_b={5,6,7,8}, vec_count=4.
REQ-035 SHALL cover: 2 pairs (9,2),(3,3), last on the 2nd -> vec_a={9,3,0,0}, vec_b={2,3,0,0}, vec_count=2.
REQ-036 SHALL cover: 3 vectors streamed continuously with vec_ready=0 -> in_ready falls after the 8th accept; raising vec_ready for 1 cycle -> in_ready=1 on the next cycle and vector 1 is presented first.
REQ-037 SHALL cover: back-to-back vectors with vec_ready=1 -> in_ready never drops, and vec_valid stays high for consecutive vectors.
REQ-038 SHALL cover: rst pulse after 2 accepted pairs of a vector and with one FULL bank -> vec_valid=0 and outputs zero; a following 4-pair vector is presented alone and correct.
REQ-039 SHALL cover: single pair (7,7) with in_last=1 -> bank goes EMPTY -> FULL directly; vec_a={7,0,0,0}, vec_count=1.
